// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output wormhole switch allocator with round-robin arbitration
module switch_allocator #(
  parameter int n_in_ports  = 5,
  parameter int n_out_ports = 5,
  parameter int idx_width   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [n_in_ports-1:0]            req_valid,
  input  logic [n_in_ports*idx_width-1:0]  req_dest,
  input  logic [n_in_ports-1:0]            req_tail,
  input  logic [n_out_ports-1:0]           out_ready,
  output logic [n_in_ports-1:0]            grant,
  output logic [n_out_ports*idx_width-1:0] sel,
  output logic [n_out_ports-1:0]           sel_valid
);

  localparam logic [idx_width-1:0] LastInit = idx_width'(n_in_ports - 1);

  // per-output registered state: lock flag, owning input, last input granted
  logic [n_out_ports-1:0] r_locked;
  logic [idx_width-1:0]   r_owner [n_out_ports];
  logic [idx_width-1:0]   r_last  [n_out_ports];

  logic [n_out_ports-1:0] w_locked_nxt;
  logic [idx_width-1:0]   w_owner_nxt [n_out_ports];
  logic [idx_width-1:0]   w_last_nxt  [n_out_ports];

  logic [idx_width-1:0]   w_dest      [n_in_ports];
  logic [n_in_ports-1:0]  w_hit       [n_out_ports];
  logic [n_in_ports-1:0]  w_own       [n_out_ports];
  logic [n_in_ports-1:0]  w_owns_any;
  logic [n_in_ports-1:0]  w_cand      [n_out_ports];
  logic [n_in_ports-1:0]  w_xfer      [n_out_ports];
  logic [n_out_ports-1:0] w_tail_xfer;
  logic [idx_width-1:0]   w_pick      [n_out_ports];
  logic [n_out_ports-1:0] w_pick_ok;

  // decode destination fields; hit = input i requests output o, own = output o locked to input i
  always_comb begin
    w_dest = '{default: '0};
    w_hit  = '{default: '0};
    w_own  = '{default: '0};
    for (int i = 0; i < n_in_ports; i++) begin
      w_dest[i] = req_dest[i*idx_width +: idx_width];
    end
    for (int o = 0; o < n_out_ports; o++) begin
      for (int i = 0; i < n_in_ports; i++) begin
        w_hit[o][i] = req_valid[i] && (w_dest[i] == idx_width'(o));
        w_own[o][i] = r_locked[o] && (r_owner[o] == idx_width'(i));
      end
    end
  end

  // candidates exclude current owners; a transfer needs owner, matching request and ready
  always_comb begin
    w_owns_any  = '0;
    w_cand      = '{default: '0};
    w_xfer      = '{default: '0};
    w_tail_xfer = '0;
    for (int o = 0; o < n_out_ports; o++) begin
      w_owns_any = w_owns_any | w_own[o];
    end
    for (int o = 0; o < n_out_ports; o++) begin
      w_cand[o]      = w_hit[o] & ~w_owns_any;
      w_xfer[o]      = w_own[o] & w_hit[o] & {n_in_ports{out_ready[o]}};
      w_tail_xfer[o] = |(w_xfer[o] & req_tail);
    end
  end

  // round-robin pick: lowest candidate above last, else lowest candidate at or below last
  always_comb begin
    w_pick    = '{default: '0};
    w_pick_ok = '0;
    for (int o = 0; o < n_out_ports; o++) begin
      for (int i = n_in_ports - 1; i >= 0; i--) begin
        if (w_cand[o][i] && (idx_width'(i) <= r_last[o])) begin
          w_pick[o]    = idx_width'(i);
          w_pick_ok[o] = 1'b1;
        end
      end
      for (int i = n_in_ports - 1; i >= 0; i--) begin
        if (w_cand[o][i] && (idx_width'(i) > r_last[o])) begin
          w_pick[o]    = idx_width'(i);
          w_pick_ok[o] = 1'b1;
        end
      end
    end
  end

  // next state: IDLE locks onto the pick, LOCKED releases only on a tail transfer
  always_comb begin
    w_locked_nxt = r_locked;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    for (int o = 0; o < n_out_ports; o++) begin
      if (!r_locked[o]) begin
        if (w_pick_ok[o]) begin
          w_locked_nxt[o] = 1'b1;
          w_owner_nxt[o]  = w_pick[o];
        end
      end else if (w_tail_xfer[o]) begin
        w_locked_nxt[o] = 1'b0;
        w_last_nxt[o]   = r_owner[o];
      end
    end
  end

  // state register; reset gives input 0 first priority everywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= '0;
      for (int o = 0; o < n_out_ports; o++) begin
        r_owner[o] <= '0;
        r_last[o]  <= LastInit;
      end
    end else begin
      r_locked <= w_locked_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
    end
  end

  // outputs: combinational flit grant, crossbar select straight from registers
  always_comb begin
    grant     = '0;
    sel       = '0;
    sel_valid = r_locked;
    for (int o = 0; o < n_out_ports; o++) begin
      grant = grant | w_xfer[o];
      sel[o*idx_width +: idx_width] = r_owner[o];
    end
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-output wormhole switch allocator for the NoC router. It arbitrates input-port requests for each output port, holds the grant from head flit to tail flit, and drives the per-output input-select fields and valids that steer the crossbar. It also returns a per-input flit-transfer grant to the input buffers. It sits between the input-buffer/route-compute stage and the crossbar.

## Interface
- `n_in_ports`, default 5, number of input ports.
- `n_out_ports`, default 5, number of output ports.
- `idx_width`, default 3, width of a port index; must satisfy 2^idx_width ≥ max(n_in_ports, n_out_ports).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  n_in_ports  input i presents a flit.
- `req_dest`  in  n_in_ports*idx_width  destination output of input i, field i at [i*idx_width +: idx_width].
- `req_tail`  in  n_in_ports  flit of input i is a tail (a head+tail flit is a single-flit packet).
- `out_ready`  in  n_out_ports  downstream of output o accepts a flit this cycle.
- `grant`  out  n_in_ports  flit of input i transfers this cycle.
- `sel`  out  n_out_ports*idx_width  input index steering output o, field o at [o*idx_width +: idx_width].
- `sel_valid`  out  n_out_ports  output o is locked to the input in its `sel` field.

## Operation
- Each output o has a registered state: IDLE or LOCKED, plus `owner[o]` (idx_width bits) and a round-robin pointer `last[o]` (the last input granted).
- Candidates for output o are inputs i with `req_valid[i]` = 1, `req_dest[i]` = o, and i not owning any output.
- IDLE: if any candidate exists, choose the first candidate found searching i = last[o]+1, last[o]+2, … modulo n_in_ports. At the clock edge, owner[o] takes that input and the state moves to LOCKED. With no candidate, the output stays IDLE.
- LOCKED: `grant[i]` is driven combinationally and equals 1 when owner[o] = i, `req_valid[i]` = 1, `req_dest[i]` = o and `out_ready[o]` = 1.
- A transfer on o occurs when `grant[owner[o]]` = 1. If a transfer occurs with `req_tail` = 1, then at the edge the output moves to IDLE and last[o] takes owner[o]. Any other transfer leaves the lock held.
- `req_valid` low, or `out_ready` low, while LOCKED: the lock is held, `grant` is 0 and no state changes.
- Outputs `sel[o]` = owner[o] and `sel_valid[o]` = (state == LOCKED) are driven directly from registers.
- An input whose `req_dest` is ≥ n_out_ports is never a candidate and never granted.
- `req_dest` must stay stable from head flit through tail flit. A change of `req_dest` mid-packet is a protocol violation; the bench asserts on it. Because of this rule, at most one output can be locked to a given input.
- Arbitration is independent per output. Different outputs may lock and transfer in the same cycle.

## Timing
- Reset (asynchronous, active-high) sets, immediately on assertion:
  - all states to IDLE, so `sel_valid` = 0 and `grant` = 0;
  - `sel` = 0;
  - last[o] = n_in_ports-1, so input 0 has first priority.
- Head latency is 1 cycle. A head flit request in cycle t to an IDLE output gives `sel_valid` = 1 and `grant` = 1 (if `out_ready` = 1) in cycle t+1.
- Lock release and new arbitration:
  - A tail transfer in cycle t leaves `sel_valid` = 0 in cycle t+1.
  - A waiting candidate is arbitrated in cycle t+1 and locked in cycle t+2, giving one bubble cycle per packet.
  - The releasing input may re-request in cycle t+1, but it has lowest priority for that output.
- Multi-flit packet: one flit transfers per cycle while `req_valid` and `out_ready` are both high.
- When tail release on o coincides with a new head flit from the same input to a different output o', the input is still an owner in cycle t, so o' does not see it as a candidate before cycle t+1.

## Test plan
- Reset state: assert `rst` mid-simulation with no clock edge → `sel_valid` = 0, `grant` = 0 and `sel` = 0 immediately; the first grant after release goes to input 0 under full contention.
- Single-flit packet: input 2 sends dest 3 with tail in cycle 0 → cycle 1 has `sel_valid[3]` = 1, sel field 3 = 2, `grant[2]` = 1; cycle 2 has `sel_valid[3]` = 0.
- Contention: inputs 0, 1 and 4 each send 3-flit packets to output 1 from cycle 0 → packets serviced in order 0, 1, 4, each lock lasting 3 cycles with a one-cycle gap. `grant[1]` = 0 and `grant[4]` = 0 while input 0 holds the lock. A repeat request from input 0 is then served after input 4.
- Backpressure: hold `out_ready[2]` = 0 for 4 cycles during a 4-flit packet from input 3 → `grant[3]` = 0 and `sel_valid[2]` = 1 through the stall; all 4 flits complete afterward and the lock releases only on the tail flit.
- Invalid destination and parallel outputs: input 0 sends dest 5 while inputs 1→0 and 2→4 are active → input 0 is never granted; outputs 0 and 4 lock in the same cycle.
- Reset during a packet: assert `rst` during flit 2 of a 4-flit packet → all locks clear at once; after release the packet head is re-arbitrated with 1-cycle latency.
